// File: rtl/axis_frame_fifo_if.sv
// AXI-Stream beat interface: data, valid, ready and end-of-frame marker.
// The master drives data/valid/last, the slave drives ready.
interface axis_frame_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_fifo.sv
// First-word-fall-through AXI-Stream frame buffer.
// Beats are stored as {tlast, tdata} and re-emitted in order on the master side.
// Per-frame length, additive checksum and frame count are collected on accepted input beats.
module axis_frame_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    axis_frame_fifo_if.slave         s_axis,
    axis_frame_fifo_if.master        m_axis,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_len,
    output logic [DATA_W-1:0]        frame_sum,
    output logic [CNT_W-1:0]         frame_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Storage and pointers; the extra pointer MSB separates full from empty.
    logic [DATA_W:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            rd_en;

    // Frame statistics state.
    logic [CNT_W-1:0]  word_cnt_q,    word_cnt_d;
    logic [DATA_W-1:0] run_sum_q,     run_sum_d;
    logic [CNT_W-1:0]  frame_len_q,   frame_len_d;
    logic [DATA_W-1:0] frame_sum_q,   frame_sum_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic              frame_done_q,  frame_done_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready is held low during reset so nothing is accepted while state is being cleared.
    assign s_axis.tready = !full && !reset;
    assign m_axis.tvalid = !empty;
    assign {m_axis.tlast, m_axis.tdata} = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en = s_axis.tvalid && s_axis.tready;
    assign rd_en = m_axis.tvalid && m_axis.tready;

    assign fill_level  = wr_ptr_q - rd_ptr_q;
    assign frame_done  = frame_done_q;
    assign frame_len   = frame_len_q;
    assign frame_sum   = frame_sum_q;
    assign frame_count = frame_count_q;

    // Write accepted beats into the storage array.
    // NOTE: the data array is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // Advance write/read pointers on their handshakes; reset empties the FIFO.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Next-state for frame statistics, updated only on accepted input beats.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        word_cnt_d    = word_cnt_q;
        run_sum_d     = run_sum_q;
        frame_len_d   = frame_len_q;
        frame_sum_d   = frame_sum_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        if (wr_en) begin
            if (s_axis.tlast) begin
                frame_len_d   = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + CNT_W'(1);
                frame_sum_d   = run_sum_q + s_axis.tdata;
                frame_count_d = frame_count_q + CNT_W'(1);
                frame_done_d  = 1'b1;
                word_cnt_d    = '0;
                run_sum_d     = '0;
            end else begin
                word_cnt_d    = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + CNT_W'(1);
                run_sum_d     = run_sum_q + s_axis.tdata;
            end
        end
    end

    // Register frame statistics; reset drops any partial frame and clears the reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q    <= '0;
            run_sum_q     <= '0;
            frame_len_q   <= '0;
            frame_sum_q   <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            run_sum_q     <= run_sum_d;
            frame_len_q   <= frame_len_d;
            frame_sum_q   <= frame_sum_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end
endmodule
